// File: rtl/jvs_rx_framer.sv
// jvs_rx_framer
//   Packet framer for the JVS RS-485 receive byte stream. It hunts for SYNC (0xE0),
//   then parses the node and length bytes, removes 0xD0 escapes, and stores the
//   payload in an internal buffer. It checks the modulo-256 checksum and then holds
//   a good, address-matched packet until the host acknowledges it.
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   i_rx_valid/i_rx_data  byte stream from the UART receiver, with i_rx_frame_err
//   o_rx_ready            byte accept (low only while a packet is held)
//   i_node_addr/i_promisc node filter
//   o_pkt_valid/node/len  held packet descriptor; i_pkt_ack releases it
//   i_rd_addr/o_rd_data   payload buffer read port, 1-cycle latency
//   o_err/o_err_code      1-cycle error pulse: 1 checksum, 2 length, 3 timeout,
//                         4 framing, 5 resync
//   o_pkt_cnt/o_err_cnt   saturating statistics
module jvs_rx_framer #(
  parameter int unsigned F_CLK_HZ   = 48_000_000,
  parameter int unsigned TIMEOUT_US = 2_000,
  parameter int unsigned BUF_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rx_valid,
  input  logic [7:0]                   i_rx_data,
  input  logic                         i_rx_frame_err,
  output logic                         o_rx_ready,
  input  logic [7:0]                   i_node_addr,
  input  logic                         i_promisc,
  output logic                         o_pkt_valid,
  output logic [7:0]                   o_pkt_node,
  output logic [8:0]                   o_pkt_len,
  input  logic                         i_pkt_ack,
  input  logic [$clog2(BUF_DEPTH)-1:0] i_rd_addr,
  output logic [7:0]                   o_rd_data,
  output logic                         o_err,
  output logic [2:0]                   o_err_code,
  output logic [15:0]                  o_pkt_cnt,
  output logic [15:0]                  o_err_cnt
);
  localparam int unsigned AW          = $clog2(BUF_DEPTH);
  localparam int unsigned TIMEOUT_CYC = F_CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned GW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CYC - 1);
  localparam logic [9:0]    DEPTH_W   = 10'(BUF_DEPTH);
  localparam logic [7:0]    SYNC      = 8'hE0;
  localparam logic [7:0]    ESC       = 8'hD0;

  typedef enum logic [2:0] {S_HUNT, S_NODE, S_LEN, S_DATA, S_SUM, S_HOLD} state_t;

  state_t        state, state_n;
  logic [7:0]    node, node_n;
  logic [8:0]    len, len_n;
  logic [7:0]    sum, sum_n;
  logic [8:0]    idx, idx_n;
  logic          esc, esc_n;
  logic [GW-1:0] gap, gap_n;
  logic          err_n;
  logic [2:0]    code_n;
  logic          wr_en, deliver, accept, active;
  logic [7:0]    d;
  logic [8:0]    len_m1;

  logic [7:0] mem [BUF_DEPTH];

  assign o_rx_ready  = (state != S_HOLD);
  assign o_pkt_valid = (state == S_HOLD);
  assign o_pkt_node  = node;
  assign o_pkt_len   = len;

  always_comb begin
    state_n = state;
    node_n  = node;
    len_n   = len;
    sum_n   = sum;
    idx_n   = idx;
    esc_n   = esc;
    gap_n   = '0;
    err_n   = 1'b0;
    code_n  = 3'd0;
    wr_en   = 1'b0;
    deliver = 1'b0;
    accept  = i_rx_valid && o_rx_ready;
    active  = (state != S_HUNT) && (state != S_HOLD);
    d       = esc ? i_rx_data + 8'd1 : i_rx_data;
    len_m1  = {1'b0, d} - 9'd1;

    if (active && !accept && gap != GAP_LAST)
      gap_n = gap + 1'b1;

    if (accept) begin
      if (state == S_HUNT) begin
        if (i_rx_data == SYNC && !i_rx_frame_err) begin
          state_n = S_NODE;
          sum_n   = '0;
          esc_n   = 1'b0;
        end
      end else if (i_rx_frame_err) begin
        err_n   = 1'b1;
        code_n  = 3'd4;
        state_n = S_HUNT;
        esc_n   = 1'b0;
      end else if (i_rx_data == SYNC) begin
        // Raw SYNC restarts the frame even when an escape is pending.
        err_n   = 1'b1;
        code_n  = 3'd5;
        state_n = S_NODE;
        sum_n   = '0;
        esc_n   = 1'b0;
      end else if (!esc && i_rx_data == ESC) begin
        esc_n = 1'b1;
      end else begin
        esc_n = 1'b0;
        case (state)
          S_NODE: begin
            node_n  = d;
            sum_n   = d;
            state_n = S_LEN;
          end
          S_LEN: begin
            if (d == 8'd0 || {1'b0, len_m1} > DEPTH_W) begin
              err_n   = 1'b1;
              code_n  = 3'd2;
              state_n = S_HUNT;
            end else begin
              len_n   = len_m1;
              sum_n   = sum + d;
              idx_n   = '0;
              state_n = (d == 8'd1) ? S_SUM : S_DATA;
            end
          end
          S_DATA: begin
            wr_en = 1'b1;
            sum_n = sum + d;
            idx_n = idx + 9'd1;
            if (idx == len - 9'd1)
              state_n = S_SUM;
          end
          S_SUM: begin
            if (d != sum) begin
              err_n   = 1'b1;
              code_n  = 3'd1;
              state_n = S_HUNT;
            end else if (i_promisc || node == i_node_addr || node == 8'hFF) begin
              deliver = 1'b1;
              state_n = S_HOLD;
            end else begin
              state_n = S_HUNT;
            end
          end
          default: ;
        endcase
      end
    end else if (active && gap == GAP_LAST) begin
      err_n   = 1'b1;
      code_n  = 3'd3;
      state_n = S_HUNT;
      esc_n   = 1'b0;
    end

    if (state == S_HOLD && i_pkt_ack)
      state_n = S_HUNT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HUNT;
      node       <= '0;
      len        <= '0;
      sum        <= '0;
      idx        <= '0;
      esc        <= 1'b0;
      gap        <= '0;
      o_err      <= 1'b0;
      o_err_code <= '0;
      o_pkt_cnt  <= '0;
      o_err_cnt  <= '0;
    end else begin
      state      <= state_n;
      node       <= node_n;
      len        <= len_n;
      sum        <= sum_n;
      idx        <= idx_n;
      esc        <= esc_n;
      gap        <= gap_n;
      o_err      <= err_n;
      o_err_code <= code_n;
      if (deliver && o_pkt_cnt != '1)
        o_pkt_cnt <= o_pkt_cnt + 16'd1;
      if (err_n && o_err_cnt != '1)
        o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[idx[AW-1:0]] <= d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      o_rd_data <= '0;
    else
      o_rd_data <= mem[i_rd_addr];
  end
endmodule

// File: tb/tb_jvs_rx_framer.sv
module tb_jvs_rx_framer;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx_valid, i_rx_frame_err;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic [7:0]  i_node_addr;
  logic        i_promisc;
  logic        o_pkt_valid;
  logic [7:0]  o_pkt_node;
  logic [8:0]  o_pkt_len;
  logic        i_pkt_ack;
  logic [3:0]  i_rd_addr;
  logic [7:0]  o_rd_data;
  logic        o_err;
  logic [2:0]  o_err_code;
  logic [15:0] o_pkt_cnt, o_err_cnt;

  int vectors = 0;
  int miscompares = 0;
  int err_seen = 0;
  logic [2:0] last_code = '0;
  logic [7:0] rd;

  // 1 MHz x 40 us -> 40-cycle inter-byte timeout
  jvs_rx_framer #(.F_CLK_HZ(1_000_000), .TIMEOUT_US(40), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .i_rx_frame_err(i_rx_frame_err), .o_rx_ready(o_rx_ready),
    .i_node_addr(i_node_addr), .i_promisc(i_promisc), .o_pkt_valid(o_pkt_valid),
    .o_pkt_node(o_pkt_node), .o_pkt_len(o_pkt_len), .i_pkt_ack(i_pkt_ack),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_err(o_err),
    .o_err_code(o_err_code), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_err) begin
      err_seen  <= err_seen + 1;
      last_code <= o_err_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic fe = 1'b0);
    @(negedge clk);
    i_rx_valid = 1'b1; i_rx_data = b; i_rx_frame_err = fe;
    @(negedge clk);
    i_rx_valid = 1'b0; i_rx_frame_err = 1'b0;
  endtask

  task automatic read_buf(input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    i_rd_addr = a;
    @(negedge clk);
    v = o_rd_data;
  endtask

  task automatic ack();
    @(negedge clk); i_pkt_ack = 1'b1;
    @(negedge clk); i_pkt_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0; i_rx_frame_err = 1'b0;
    i_node_addr = 8'h01; i_promisc = 1'b0; i_pkt_ack = 1'b0; i_rd_addr = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_ready", 32'(o_rx_ready), 32'd1);
    chk("rst_valid", 32'(o_pkt_valid), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_pkt_cnt", 32'(o_pkt_cnt), 32'd0);
    chk("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    chk("rst_len", 32'(o_pkt_len), 32'd0);

    // basic packet
    send(8'hE0); send(8'h01); send(8'h03); send(8'h11); send(8'h22); send(8'h37);
    idle(2);
    chk("basic_valid", 32'(o_pkt_valid), 32'd1);
    chk("basic_node", 32'(o_pkt_node), 32'h01);
    chk("basic_len", 32'(o_pkt_len), 32'd2);
    chk("basic_hold_ready", 32'(o_rx_ready), 32'd0);
    read_buf(4'd0, rd); chk("basic_buf0", 32'(rd), 32'h11);
    read_buf(4'd1, rd); chk("basic_buf1", 32'(rd), 32'h22);
    ack(); idle(1);
    chk("basic_ack_valid", 32'(o_pkt_valid), 32'd0);
    chk("basic_ack_ready", 32'(o_rx_ready), 32'd1);
    chk("basic_pkt_cnt", 32'(o_pkt_cnt), 32'd1);
    chk("basic_no_err", 32'(err_seen), 32'd0);

    // escaped payload byte
    send(8'hE0); send(8'h01); send(8'h02); send(8'hD0); send(8'hDF); send(8'hE3);
    idle(2);
    chk("esc_valid", 32'(o_pkt_valid), 32'd1);
    chk("esc_len", 32'(o_pkt_len), 32'd1);
    read_buf(4'd0, rd); chk("esc_buf0", 32'(rd), 32'hE0);
    chk("esc_no_err", 32'(err_seen), 32'd0);
    ack(); idle(1);

    // bad checksum
    send(8'hE0); send(8'h01); send(8'h03); send(8'h11); send(8'h22); send(8'h38);
    idle(2);
    chk("cks_err_seen", 32'(err_seen), 32'd1);
    chk("cks_code", 32'(last_code), 32'd1);
    chk("cks_valid", 32'(o_pkt_valid), 32'd0);
    chk("cks_err_cnt", 32'(o_err_cnt), 32'd1);

    // resync mid-payload
    send(8'hE0); send(8'h01); send(8'h05); send(8'h11);
    send(8'hE0); send(8'h01); send(8'h02); send(8'hAA); send(8'hAD);
    idle(2);
    chk("resync_err_seen", 32'(err_seen), 32'd2);
    chk("resync_code", 32'(last_code), 32'd5);
    chk("resync_valid", 32'(o_pkt_valid), 32'd1);
    chk("resync_len", 32'(o_pkt_len), 32'd1);
    read_buf(4'd0, rd); chk("resync_buf0", 32'(rd), 32'hAA);
    ack(); idle(1);

    // raw SYNC directly after an escape byte still resyncs
    send(8'hE0); send(8'h01); send(8'h03); send(8'hD0); send(8'hE0);
    idle(2);
    chk("escsync_err_seen", 32'(err_seen), 32'd3);
    chk("escsync_code", 32'(last_code), 32'd5);
    send(8'h01); send(8'h02); send(8'hAA); send(8'hAD);
    idle(2);
    chk("escsync_valid", 32'(o_pkt_valid), 32'd1);
    ack(); idle(1);

    // length errors: zero, and one past the buffer depth (18 -> 17 > 16)
    send(8'hE0); send(8'h01); send(8'h00);
    idle(2);
    chk("len0_err_seen", 32'(err_seen), 32'd4);
    chk("len0_code", 32'(last_code), 32'd2);
    send(8'hE0); send(8'h01); send(8'h12);
    idle(2);
    chk("lenbig_err_seen", 32'(err_seen), 32'd5);
    chk("lenbig_code", 32'(last_code), 32'd2);

    // full-depth payload: length 17 -> 16 bytes 00..0F, sum 01+11+78 = 8A
    send(8'hE0); send(8'h01); send(8'h11);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h8A);
    idle(2);
    chk("full_valid", 32'(o_pkt_valid), 32'd1);
    chk("full_len", 32'(o_pkt_len), 32'd16);
    read_buf(4'd0, rd);  chk("full_buf0", 32'(rd), 32'h00);
    read_buf(4'd15, rd); chk("full_buf15", 32'(rd), 32'h0F);
    chk("full_no_err", 32'(err_seen), 32'd5);
    ack(); idle(1);

    // inter-byte timeout, then a good packet
    send(8'hE0); send(8'h01); send(8'h03); send(8'h11);
    idle(30);
    chk("to_not_yet", 32'(err_seen), 32'd5);
    idle(15);
    chk("to_err_seen", 32'(err_seen), 32'd6);
    chk("to_code", 32'(last_code), 32'd3);
    send(8'hE0); send(8'h01); send(8'h02); send(8'hAA); send(8'hAD);
    idle(2);
    chk("to_next_valid", 32'(o_pkt_valid), 32'd1);
    ack(); idle(1);

    // framing: ignored while hunting, error inside a frame (beats resync)
    send(8'hE0, 1'b1); send(8'h01);
    idle(2);
    chk("fe_hunt_ignored", 32'(err_seen), 32'd6);
    send(8'hE0); send(8'hE0, 1'b1);
    idle(2);
    chk("fe_err_seen", 32'(err_seen), 32'd7);
    chk("fe_code", 32'(last_code), 32'd4);

    // node filtering and broadcast
    i_node_addr = 8'h02;
    send(8'hE0); send(8'h01); send(8'h02); send(8'hAA); send(8'hAD);
    idle(2);
    chk("filt_valid", 32'(o_pkt_valid), 32'd0);
    chk("filt_no_err", 32'(err_seen), 32'd7);
    send(8'hE0); send(8'hFF); send(8'h02); send(8'hAA); send(8'hAB);
    idle(2);
    chk("bcast_valid", 32'(o_pkt_valid), 32'd1);
    chk("bcast_node", 32'(o_pkt_node), 32'hFF);
    @(negedge clk); i_rx_valid = 1'b1; i_rx_data = 8'hE0;
    idle(3);
    chk("hold_ready", 32'(o_rx_ready), 32'd0);
    chk("hold_valid", 32'(o_pkt_valid), 32'd1);
    i_rx_valid = 1'b0;
    ack(); idle(1);
    chk("bcast_ack_valid", 32'(o_pkt_valid), 32'd0);

    chk("final_pkt_cnt", 32'(o_pkt_cnt), 32'd7);
    chk("final_err_cnt", 32'(o_err_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
